// File: rtl/control_ajuste_campos.sv
// PS/2 scan-code edit controller: enters/leaves edit mode, selects a field, forwards up/down commands.
// Latency: one cycle from got_data to registered outputs; no backpressure, every strobe is consumed.
module control_ajuste_campos #(
    parameter int            NUM_CAMPOS = 3,
    parameter int            TW         = 24,
    parameter logic [TW-1:0] TIMEOUT    = TW'(12_000_000)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       got_data,
    input  logic [7:0] dato,
    output logic [7:0] estado,
    output logic [1:0] en,
    output logic [7:0] Cambio,
    output logic       got_data_o,
    output logic       editando
);
    localparam logic [1:0] MAXC = 2'(NUM_CAMPOS);

    localparam logic [7:0] K_EDIT = 8'h7D;
    localparam logic [7:0] K_ESC  = 8'h76;
    localparam logic [7:0] K_NEXT = 8'h74;
    localparam logic [7:0] K_PREV = 8'h6B;
    localparam logic [7:0] K_UP   = 8'h73;
    localparam logic [7:0] K_DOWN = 8'h72;
    localparam logic [7:0] K_BRK  = 8'hF0;
    localparam logic [7:0] K_EXT  = 8'hE0;

    typedef enum logic {REPOSO, EDICION} state_t;

    state_t        state, state_nx;
    logic [1:0]    en_nx;
    logic [7:0]    cambio_nx;
    logic          strobe_nx;
    logic          brk, brk_nx;
    logic [TW-1:0] cnt, cnt_nx;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= REPOSO;
            en         <= 2'd0;
            estado     <= 8'h00;
            Cambio     <= 8'h00;
            got_data_o <= 1'b0;
            editando   <= 1'b0;
            brk        <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nx;
            en         <= en_nx;
            estado     <= (state_nx == EDICION) ? K_EDIT : 8'h00;
            Cambio     <= cambio_nx;
            got_data_o <= strobe_nx;
            editando   <= (state_nx == EDICION);
            brk        <= brk_nx;
            cnt        <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        en_nx     = en;
        cambio_nx = Cambio;
        strobe_nx = 1'b0;
        brk_nx    = brk;
        cnt_nx    = cnt;
        accept    = 1'b0;

        // Release codes arm the break flag; the byte after it is swallowed. E0 is transparent.
        if (got_data) begin
            if (dato == K_BRK)
                brk_nx = 1'b1;
            else if (dato != K_EXT) begin
                if (brk)
                    brk_nx = 1'b0;
                else
                    accept = 1'b1;
            end
        end

        case (state)
            REPOSO: begin
                cnt_nx = '0;
                if (accept && dato == K_EDIT) begin
                    state_nx = EDICION;
                    en_nx    = 2'd1;
                end
            end
            EDICION: begin
                if (got_data) begin
                    cnt_nx = '0;
                    if (accept) begin
                        case (dato)
                            K_EDIT, K_ESC: begin
                                state_nx = REPOSO;
                                en_nx    = 2'd0;
                            end
                            K_NEXT: en_nx = (en == MAXC) ? 2'd1 : en + 2'd1;
                            K_PREV: en_nx = (en == 2'd1) ? MAXC : en - 2'd1;
                            K_UP, K_DOWN: begin
                                cambio_nx = dato;
                                strobe_nx = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else if (cnt == TIMEOUT - 1'b1) begin
                    state_nx = REPOSO;
                    en_nx    = 2'd0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = REPOSO;
        endcase
    end
endmodule

// File: tb/tb_control_ajuste_campos.sv
// Bench for control_ajuste_campos: directed scan-code sequences, reference model checked every cycle.
module tb_control_ajuste_campos;
    localparam int N  = 3;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       got_data = 1'b0;
    logic [7:0] dato = 8'h00;
    logic [7:0] estado;
    logic [1:0] en;
    logic [7:0] Cambio;
    logic       got_data_o;
    logic       editando;

    control_ajuste_campos #(.NUM_CAMPOS(N), .TW(24), .TIMEOUT(24'd16)) dut (
        .clk(clk), .rst(rst), .got_data(got_data), .dato(dato),
        .estado(estado), .en(en), .Cambio(Cambio),
        .got_data_o(got_data_o), .editando(editando)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edit mode flag, selected field, last command, pending release, idle cycles.
    int m_edit, m_field, m_cmd, m_pulse, m_brk, m_idle;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edit = 0; m_field = 0; m_cmd = 0; m_pulse = 0; m_brk = 0; m_idle = 0;
        end else begin
            m_pulse = 0;
            if (got_data) begin
                m_idle = 0;
                if (dato == 8'hF0) m_brk = 1;
                else if (dato == 8'hE0) ;
                else if (m_brk == 1) m_brk = 0;
                else if (m_edit == 0) begin
                    if (dato == 8'h7D) begin m_edit = 1; m_field = 1; end
                end else begin
                    if (dato == 8'h7D || dato == 8'h76) begin m_edit = 0; m_field = 0; end
                    else if (dato == 8'h74) m_field = m_field % N + 1;
                    else if (dato == 8'h6B) m_field = (m_field + N - 2) % N + 1;
                    else if (dato == 8'h73 || dato == 8'h72) begin m_cmd = dato; m_pulse = 1; end
                end
            end else if (m_edit == 1) begin
                m_idle++;
                if (m_idle == TO) begin m_edit = 0; m_field = 0; m_idle = 0; end
            end else m_idle = 0;
        end
    end

    // A day counter driven from the command bus, plus a pulse count.
    int day = 1;
    int day_max = 1;
    int pulses = 0;

    always @(negedge clk) begin
        check("estado", estado, m_edit ? 8'h7D : 8'h00);
        check("en", en, m_field);
        check("editando", editando, m_edit);
        check("got_data_o", got_data_o, m_pulse);
        check("Cambio", Cambio, m_cmd);
        if (got_data_o) begin
            pulses++;
            if (Cambio == 8'h73) day = (day == 31) ? 1 : day + 1;
            else day = (day == 1) ? 31 : day - 1;
            if (day > day_max) day_max = day;
        end
    end

    task automatic send(input logic [7:0] b);
        got_data = 1'b1;
        dato     = b;
        @(posedge clk);
        #1 got_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        idle(3);
        rst = 1'b0;
        check("lit_reset_en", en, 0);
        check("lit_reset_estado", estado, 0);

        send(8'h73);
        check("lit_idle_up_no_strobe", got_data_o, 0);
        send(8'h7D);
        check("lit_enter_en", en, 1);
        check("lit_enter_estado", estado, 8'h7D);
        check("lit_enter_editando", editando, 1);

        send(8'h74); check("lit_next_2", en, 2);
        send(8'h74); check("lit_next_3", en, 3);
        send(8'h74); check("lit_next_wrap", en, 1);
        send(8'h6B); check("lit_prev_wrap", en, 3);
        send(8'h6B); check("lit_prev_2", en, 2);

        p0 = pulses;
        send(8'h73);
        check("lit_up_strobe", got_data_o, 1);
        check("lit_up_cambio", Cambio, 8'h73);
        send(8'hF0);
        check("lit_strobe_single", got_data_o, 0);
        send(8'h73);
        check("lit_release_no_strobe", got_data_o, 0);
        send(8'h72);
        check("lit_down_strobe", got_data_o, 1);
        check("lit_down_cambio", Cambio, 8'h72);
        idle(1);
        check("lit_pulse_count", pulses - p0, 2);
        check("lit_day_final", day, 1);
        check("lit_day_peak", day_max, 2);

        send(8'hE0); send(8'h74);
        check("lit_ext_next", en, 3);
        send(8'hF0); send(8'h7D);
        check("lit_release_edit_stays", editando, 1);

        idle(15);
        check("lit_timeout_not_yet", editando, 1);
        idle(1);
        check("lit_timeout_exit", editando, 0);
        check("lit_timeout_en", en, 0);

        send(8'h7D);
        idle(9);
        send(8'h11);
        idle(15);
        check("lit_postponed_not_yet", en, 1);
        idle(1);
        check("lit_postponed_exit", en, 0);

        send(8'h7D); send(8'h6B);
        check("lit_pre_rst_en", en, 3);
        send(8'hF0);
        #2 rst = 1'b1;
        #1;
        check("lit_arst_en", en, 0);
        check("lit_arst_estado", estado, 0);
        check("lit_arst_editando", editando, 0);
        check("lit_arst_cambio", Cambio, 0);
        check("lit_arst_strobe", got_data_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h73);
        check("lit_post_rst_no_strobe", got_data_o, 0);
        send(8'h7D);
        check("lit_brk_lost_enter", editando, 1);
        send(8'h76);
        check("lit_esc_exit", editando, 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
